acc_block_arbiter: RTL and testbench

- Shares one block-granular accelerator unit among NUM_CH requester streams.
- The accelerator consumes exactly BLOCK_WORDS 64-bit words, then produces exactly BLOCK_WORDS words.
- The block grants one channel per block (round-robin), forwards that channel's input block to the accelerator, and routes the result block back to the same channel's output.
- Sits between the per-channel FIFO controllers and the accelerator's consumer/producer valid-ready ports.

---
 rtl/acc_block_arbiter.sv | 178 +++++++++++++++++
 tb/tb_acc_block_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/acc_block_arbiter.sv
// Round-robin, block-granular sharing of one accelerator among NUM_CH streams; zero-latency muxing, no storage.
// Optional watchdog: define ACC_BLOCK_ARB_WATCHDOG_EN to abort blocks stalled for TIMEOUT_CYCLES cycles.
module acc_block_arbiter #(
    parameter int NUM_CH         = 4,
    parameter int BLOCK_WORDS    = 128,
    parameter int DATA_W         = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic [NUM_CH-1:0]          req_valid,
    output logic [NUM_CH-1:0]          req_ready,
    input  logic [NUM_CH*DATA_W-1:0]   req_data,
    output logic [NUM_CH-1:0]          rsp_valid,
    input  logic [NUM_CH-1:0]          rsp_ready,
    output logic [NUM_CH*DATA_W-1:0]   rsp_data,
    output logic                       acc_in_valid,
    input  logic                       acc_in_ready,
    output logic [DATA_W-1:0]          acc_in_data,
    input  logic                       acc_out_valid,
    output logic                       acc_out_ready,
    input  logic [DATA_W-1:0]          acc_out_data,
    output logic                       busy,
    output logic [$clog2(NUM_CH)-1:0]  owner,
    output logic                       timeout_err
);

    localparam int OW = $clog2(NUM_CH);
    localparam int CW = $clog2(BLOCK_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FEED,
        S_DRAIN
    } state_t;

    state_t        state_q, state_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [OW-1:0] last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          gnt_found;
    logic [OW-1:0] gnt_idx;
    logic          in_hs, out_hs;

    // Search starts one past the previous grant so continuous requesters rotate.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            if (!gnt_found && req_valid[(int'(last_q) + k) % NUM_CH]) begin
                gnt_found = 1'b1;
                gnt_idx   = OW'((int'(last_q) + k) % NUM_CH);
            end
        end
    end

    assign in_hs  = (state_q == S_FEED)  && req_valid[owner_q] && acc_in_ready;
    assign out_hs = (state_q == S_DRAIN) && acc_out_valid && rsp_ready[owner_q];

    always_comb begin
        req_ready     = '0;
        rsp_valid     = '0;
        rsp_data      = '0;
        acc_in_valid  = 1'b0;
        acc_in_data   = '0;
        acc_out_ready = 1'b0;
        case (state_q)
            S_FEED: begin
                acc_in_valid       = req_valid[owner_q];
                req_ready[owner_q] = acc_in_ready;
                acc_in_data        = req_data[int'(owner_q)*DATA_W +: DATA_W];
            end
            S_DRAIN: begin
                rsp_valid[owner_q]                       = acc_out_valid;
                acc_out_ready                            = rsp_ready[owner_q];
                rsp_data[int'(owner_q)*DATA_W +: DATA_W] = acc_out_data;
            end
            default: ;
        endcase
    end

`ifdef ACC_BLOCK_ARB_WATCHDOG_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0] wd_q, wd_d;
    logic          err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (enable && gnt_found) begin
                    owner_d = gnt_idx;
                    cnt_d   = '0;
                    state_d = S_FEED;
                end
            end
            S_FEED: begin
                if (in_hs) begin
                    if (cnt_q == CW'(BLOCK_WORDS - 1)) begin
                        cnt_d   = '0;
                        state_d = S_DRAIN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (out_hs) begin
                    if (cnt_q == CW'(BLOCK_WORDS - 1)) begin
                        cnt_d   = '0;
                        last_d  = owner_q;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef ACC_BLOCK_ARB_WATCHDOG_EN
        wd_d  = '0;
        err_d = err_q;
        if (state_q != S_IDLE && !in_hs && !out_hs && state_d == state_q) begin
            if (wd_q == WW'(TIMEOUT_CYCLES - 1)) begin
                // The stuck block is dropped; the accelerator needs a software reset.
                err_d   = 1'b1;
                last_d  = owner_q;
                cnt_d   = '0;
                state_d = S_IDLE;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            owner_q <= '0;
            last_q  <= OW'(NUM_CH - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef ACC_BLOCK_ARB_WATCHDOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end

    assign timeout_err = err_q;
`else
    // Without the watchdog the flag is constant low; the limit only matters when the feature is built.
    assign timeout_err = (TIMEOUT_CYCLES < 0);
`endif

    assign busy  = (state_q != S_IDLE);
    assign owner = owner_q;

endmodule

// File: tb/tb_acc_block_arbiter.sv
// Directed bench: table of arbitration scenarios, each run as a full block through an echo(+1) accelerator model.
module tb_acc_block_arbiter;

    localparam int NCH = 4;
    localparam int BW  = 128;
    localparam int DW  = 64;
    localparam int TO  = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic [NCH-1:0]    req_valid;
    logic [NCH-1:0]    req_ready;
    logic [NCH*DW-1:0] req_data;
    logic [NCH-1:0]    rsp_valid;
    logic [NCH-1:0]    rsp_ready;
    logic [NCH*DW-1:0] rsp_data;
    logic              acc_in_valid;
    logic              acc_in_ready;
    logic [DW-1:0]     acc_in_data;
    logic              acc_out_valid;
    logic              acc_out_ready;
    logic [DW-1:0]     acc_out_data;
    logic              busy;
    logic [1:0]        owner;
    logic              timeout_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    acc_block_arbiter #(
        .NUM_CH(NCH), .BLOCK_WORDS(BW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .acc_in_valid(acc_in_valid), .acc_in_ready(acc_in_ready), .acc_in_data(acc_in_data),
        .acc_out_valid(acc_out_valid), .acc_out_ready(acc_out_ready), .acc_out_data(acc_out_data),
        .busy(busy), .owner(owner), .timeout_err(timeout_err)
    );

    typedef struct {
        logic [NCH-1:0] mask;
        int             exp_owner;
        bit             bp;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk($sformatf("%s_busy", tag), 64'(busy), 0);
        chk($sformatf("%s_owner", tag), 64'(owner), 0);
        chk($sformatf("%s_req_ready", tag), 64'(req_ready), 0);
        chk($sformatf("%s_rsp_valid", tag), 64'(rsp_valid), 0);
        chk($sformatf("%s_acc_in_valid", tag), 64'(acc_in_valid), 0);
        chk($sformatf("%s_acc_out_ready", tag), 64'(acc_out_ready), 0);
        chk($sformatf("%s_acc_in_data", tag), acc_in_data, 0);
        chk($sformatf("%s_rsp_data_nz", tag), 64'(rsp_data != '0), 0);
        chk($sformatf("%s_timeout_err", tag), 64'(timeout_err), 0);
    endtask

    // One block: grant check, then feed/drain with the accelerator echoing each word +1.
    task automatic run_block(input logic [NCH-1:0] mask, input int exp_owner, input bit bp,
                             input int drop_en_at, input int abort_at, input int stall_at);
        logic [DW-1:0] acc_q[$];
        int in_cnt = 0;
        int out_cnt = 0;
        int cyc = 0;
        int stray = 0;
        @(negedge clk);
        chk("idle_busy", 64'(busy), 0);
        req_valid     = mask;
        acc_in_ready  = 1'b1;
        acc_out_valid = 1'b0;
        acc_out_data  = '0;
        rsp_ready     = '1;
        for (int i = 0; i < NCH; i++) req_data[i*DW +: DW] = {32'(i), 32'(0)};
        #1;
        chk("idle_no_data", 64'({acc_in_valid, req_ready}), 0);
        @(negedge clk);
        chk("grant_owner", 64'(owner), 64'(exp_owner));
        chk("grant_busy", 64'(busy), 1);
        while (1) begin
            if (abort_at >= 0 && out_cnt == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk_zero("abort");
                req_valid = '0;
                return;
            end
            if (stall_at >= 0 && out_cnt == stall_at) begin
                rsp_ready     = '0;
                req_valid     = '0;
                acc_in_ready  = 1'b0;
                acc_out_valid = 1'b1;
                acc_out_data  = acc_q[out_cnt];
                repeat (20) @(negedge clk);
                #1;
`ifdef ACC_BLOCK_ARB_WATCHDOG_EN
                chk("wd_err", 64'(timeout_err), 1);
                chk("wd_idle", 64'(busy), 0);
                chk("wd_out_ready", 64'(acc_out_ready), 0);
`else
                chk("stall_err", 64'(timeout_err), 0);
                chk("stall_busy", 64'(busy), 1);
                chk("stall_rsp_valid", 64'(rsp_valid[exp_owner]), 1);
`endif
                return;
            end
            if (drop_en_at >= 0 && in_cnt == drop_en_at) enable = 1'b0;
            for (int i = 0; i < NCH; i++) begin
                req_valid[i] = mask[i] && !(bp && i == exp_owner && $urandom_range(0, 3) == 0);
                req_data[i*DW +: DW] = {32'(i), 32'(in_cnt)};
                rsp_ready[i] = !bp || ($urandom_range(0, 1) == 1);
            end
            acc_in_ready  = (in_cnt < BW) && (!bp || $urandom_range(0, 1) == 1);
            acc_out_valid = (in_cnt == BW) && (out_cnt < BW);
            acc_out_data  = acc_out_valid ? acc_q[out_cnt] : '0;
            #1;
            for (int i = 0; i < NCH; i++) begin
                if (i != exp_owner && (req_ready[i] || rsp_valid[i] || rsp_data[i*DW +: DW] != '0))
                    stray++;
            end
            if (in_cnt == BW && acc_in_valid) stray++;
            if (in_cnt < BW && acc_out_ready) stray++;
            if (acc_in_valid && acc_in_ready) begin
                chk($sformatf("in_word%0d", in_cnt), acc_in_data, {32'(exp_owner), 32'(in_cnt)});
                acc_q.push_back(acc_in_data + 64'd1);
                in_cnt++;
            end
            if (rsp_valid[exp_owner] && rsp_ready[exp_owner]) begin
                chk($sformatf("out_word%0d", out_cnt), rsp_data[exp_owner*DW +: DW],
                    {32'(exp_owner), 32'(out_cnt)} + 64'd1);
                out_cnt++;
            end
            cyc++;
            if (out_cnt == BW || cyc >= 4000) break;
            @(negedge clk);
        end
        chk("in_count", 64'(in_cnt), 64'(BW));
        chk("out_count", 64'(out_cnt), 64'(BW));
        chk("stray", 64'(stray), 0);
    endtask

    initial begin
        tbl[0] = '{4'b0100, 2, 1'b0};
        tbl[1] = '{4'b1111, 3, 1'b1};
        tbl[2] = '{4'b0011, 0, 1'b1};
        tbl[3] = '{4'b0011, 1, 1'b0};
        tbl[4] = '{4'b0011, 0, 1'b1};
        tbl[5] = '{4'b1010, 1, 1'b0};
        tbl[6] = '{4'b1010, 3, 1'b1};
        tbl[7] = '{4'b0100, 2, 1'b0};

        rst_n         = 1'b0;
        enable        = 1'b1;
        req_valid     = '1;
        req_data      = '1;
        rsp_ready     = '1;
        acc_in_ready  = 1'b1;
        acc_out_valid = 1'b1;
        acc_out_data  = '1;
        repeat (3) @(negedge clk);
        #1;
        chk_zero("rst");
        @(negedge clk);
        req_valid     = '0;
        acc_out_valid = 1'b0;
        rst_n         = 1'b1;

        for (int t = 0; t < 8; t++)
            run_block(tbl[t].mask, tbl[t].exp_owner, tbl[t].bp, -1, -1, -1);

        // enable falls mid-feed: block still completes, then nothing is granted until re-enabled
        run_block(4'b0010, 1, 1'b0, 60, -1, -1);
        chk("en_drop_enable_low", 64'(enable), 0);
        @(negedge clk);
        req_valid = 4'b1000;
        repeat (5) @(negedge clk);
        #1;
        chk("en_low_no_grant", 64'(busy), 0);
        req_valid = '0;
        enable    = 1'b1;
        run_block(4'b1000, 3, 1'b0, -1, -1, -1);

        // reset during drain, then rotation restarts from channel 0
        run_block(4'b0100, 2, 1'b1, -1, 40, -1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int r = 0; r < 8; r++)
            run_block(4'b1111, r % NCH, r >= 4, -1, -1, -1);

        run_block(4'b1111, 0, 1'b0, -1, -1, 50);
`ifdef ACC_BLOCK_ARB_WATCHDOG_EN
        run_block(4'b1111, 1, 1'b0, -1, -1, -1);
`else
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_zero("stall_rst");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
